// File: rtl/cfg_to_iosf_req_sequencer.sv
// -----------------------------------------------------------------------------
// cfg_to_iosf_req_sequencer
//
// Read-side consumer of the cfg-to-IOSF dual-clock FIFO. It runs entirely in
// the FIFO read clock domain and handles one transaction at a time:
//   1. Pops one 69-bit config entry.
//   2. Presents it as a single-outstanding request with a valid/ready handshake.
//   3. Waits for the completion, or times out.
//   4. Returns a one-cycle response to the cfg side.
//
// Ports
//   clk, rst_n        FIFO read clock, asynchronous active-low reset
//   fifo_rdempty      FIFO empty flag
//   fifo_q            FIFO data (non-showahead, valid the cycle after rdreq)
//                     [68] is_write, [67:64] be, [63:32] addr, [31:0] wdata
//   fifo_rdreq        FIFO pop strobe
//   req_*             request channel (valid/ready), fields stable while valid
//   cpl_*             completion strobe with error flag and read data
//   rsp_*             one-cycle response pulse with read data and status
//   busy              transaction in progress (state is not IDLE)
//   err_count         saturating count of errored or timed-out transactions
//
// Reset aborts any transaction in flight without producing a response. An
// entry that was already popped from the FIFO is dropped.
// -----------------------------------------------------------------------------
module cfg_to_iosf_req_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_rdempty,
  input  logic [68:0]       fifo_q,
  output logic              fifo_rdreq,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [3:0]        req_be,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  input  logic              cpl_valid,
  input  logic              cpl_err,
  input  logic [31:0]       cpl_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_WAIT_CPL,
    S_RSP
  } state_t;

  // Counter value on the last WAIT_CPL cycle before the timeout fires.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic                run_q;
  logic                req_write_q, req_write_d;
  logic [3:0]          req_be_q, req_be_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [31:0]         req_wdata_q, req_wdata_d;
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      run_q         <= 1'b0;
      req_write_q   <= 1'b0;
      req_be_q      <= '0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      tmo_cnt_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      // Pops are held off until the first clock after reset release so that
      // fifo_rdreq stays low for the whole reset interval.
      run_q         <= 1'b1;
      req_write_q   <= req_write_d;
      req_be_q      <= req_be_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      err_count_q   <= err_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_write_d   = req_write_q;
    req_be_d      = req_be_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    tmo_cnt_d     = tmo_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    err_count_d   = err_count_q;
    fifo_rdreq    = 1'b0;
    req_valid     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run_q && !fifo_rdempty) begin
          fifo_rdreq = 1'b1;
          state_d    = S_FETCH;
        end
      end

      // fifo_q is valid now, one cycle after the pop.
      S_FETCH: begin
        req_write_d = fifo_q[68];
        req_be_d    = fifo_q[67:64];
        req_addr_d  = fifo_q[32 +: ADDR_W];
        req_wdata_d = fifo_q[31:0];
        state_d     = S_REQ;
      end

      S_REQ: begin
        req_valid = 1'b1;
        if (req_ready) begin
          tmo_cnt_d = '0;
          state_d   = S_WAIT_CPL;
        end
      end

      // A completion takes priority over a timeout landing on the same cycle.
      S_WAIT_CPL: begin
        if (cpl_valid) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = cpl_err;
          rsp_rdata_d = (!req_write_q && !cpl_err) ? cpl_rdata : 32'h0;
          state_d     = S_RSP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = 32'h0;
          state_d       = S_RSP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      // Response pulse is on the outputs during this cycle.
      S_RSP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counted on the same edge the errored response pulse is launched.
    if (rsp_err_d && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  assign req_write   = req_write_q;
  assign req_be      = req_be_q;
  assign req_addr    = req_addr_q;
  assign req_wdata   = req_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign err_count   = err_count_q;

endmodule

// File: doc/cfg_to_iosf_req_sequencer.md
Name: cfg_to_iosf_req_sequencer

Overview:
- Read-side consumer of the cfg-to-IOSF dual-clock FIFO, running in the FIFO read clock domain.
- Pops one 69-bit config entry at a time, decodes it into a single-outstanding IOSF sideband-style request, and holds a valid/ready handshake until it is accepted.
- Waits for the completion, or times out, before fetching the next entry.
- Returns read data and error status to the cfg side.

Parameters:
- ADDR_W, 32, address field width. Entry layout is fixed for the default value.
- TIMEOUT_CYC, 4096, cycles allowed in WAIT_CPL before a timeout is declared. Must be at least 1.
- CNT_W, 16, width of the timeout counter and the error counter.

Ports:
- clk  in  1  FIFO read clock; all logic is on this clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_rdempty  in  1  FIFO rdempty.
- fifo_q  in  69  FIFO q. Non-showahead: q is valid on the cycle after rdreq. Layout: [68] is_write, [67:64] byte enable, [63:32] address, [31:0] write data.
- fifo_rdreq  out  1  FIFO pop strobe.
- req_valid  out  1  request valid.
- req_ready  in  1  request accepted.
- req_write  out  1  1 = write, 0 = read.
- req_be  out  4  byte enables.
- req_addr  out  ADDR_W  address.
- req_wdata  out  32  write data.
- cpl_valid  in  1  completion strobe, 1 cycle.
- cpl_err  in  1  completion error, qualified by cpl_valid.
- cpl_rdata  in  32  read data, qualified by cpl_valid.
- rsp_valid  out  1  1-cycle pulse per finished transaction.
- rsp_rdata  out  32  read data. Zero for writes, errors and timeouts.
- rsp_err  out  1  completion error or timeout.
- rsp_timeout  out  1  the transaction timed out.
- busy  out  1  state is not IDLE.
- err_count  out  CNT_W  saturating count of errored or timed-out transactions.

Behaviour:
- Reset: every output is 0, state is IDLE, and both counters are 0. Reset asserted mid-transaction aborts it immediately with no response. An entry already popped is lost; this is acceptable and documented.
- IDLE: if fifo_rdempty==0, drive fifo_rdreq=1 for exactly one cycle and go to FETCH. fifo_rdreq is never asserted in any other state, and never while rdempty==1.
- FETCH: one cycle. Register fifo_q into the request fields, then go to REQ.
- REQ: req_valid=1 with fields held stable until req_ready==1. The handshake completes on the cycle valid and ready are both 1, then go to WAIT_CPL. req_valid drops the following cycle. req_ready while req_valid==0 is ignored.
- WAIT_CPL:
  - The timeout counter clears on entry and increments each cycle.
  - cpl_valid: capture rsp_rdata (cpl_rdata for a successful read, else 0) and rsp_err=cpl_err. Pulse rsp_valid the next cycle, then go to IDLE.
  - Counter reaching TIMEOUT_CYC-1 without cpl_valid: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, then go to IDLE.
  - cpl_valid on the same cycle the timeout would fire: the completion wins and there is no timeout.
- cpl_valid outside WAIT_CPL (a stale completion after a timeout) is ignored. It does not pulse rsp_valid or change err_count.
- err_count increments by 1 on each rsp_valid with rsp_err==1 and saturates at all-ones.
- Throughput:
  - Minimum 5 cycles per transaction: IDLE, FETCH, REQ, WAIT_CPL, RSP.
  - After the rsp_valid cycle, state returns to IDLE. The next rdreq may issue on the following cycle.
- rsp_valid, rsp_err and rsp_timeout are registered 1-cycle pulses.

Test Plan:
- Read with immediate accept: push 69'h0_F_0000_1000_0000_0000, req_ready=1, cpl_valid with rdata 32'hDEADBEEF 3 cycles after accept. Required:
  - fifo_rdreq for exactly 1 cycle.
  - req_addr=32'h1000, req_write=0, req_be=4'hF.
  - rsp_valid pulse with rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Write with backpressure: entry with is_write=1, be=4'h3, addr=32'h20, wdata=32'h1234; req_ready held low 10 cycles. Required:
  - req_valid and all fields stable for all 10 cycles.
  - Exactly one handshake.
  - rsp_rdata=0.
- Timeout with TIMEOUT_CYC=16: no cpl_valid is returned. Required:
  - rsp_valid with rsp_err=1, rsp_timeout=1 exactly 16 cycles after entering WAIT_CPL.
  - err_count=1.
  - A late cpl_valid is ignored.
- Completion on the timeout cycle: cpl_valid on counter=15. Required: normal response with rsp_timeout=0.
- Empty FIFO and back-to-back traffic: with rdempty=1 held, no rdreq and busy=0. Then push 3 entries with ready=1 and 1-cycle completions. Required: 3 responses in order, no rdreq issued while busy.
- Async reset in REQ: assert rst_n=0. Required: req_valid=0 and busy=0 immediately, err_count=0, no response after release.
